// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunk adder.
// Holds the FSM state enum, sizing helpers and the full-adder cell.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Number of DIGIT-wide slices, i.e. cycles per operation.
    function automatic int ndig_f(input int width, input int digit);
        return width / digit;
    endfunction

    // Slice counter width; never narrower than one bit.
    function automatic int cnt_w_f(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

    // One-bit full-adder cell, result packed as {carry, sum}.
    function automatic logic [1:0] full_add(
        input logic x,
        input logic y,
        input logic ci
    );
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Ports: x, y (DIGIT) operands; ci carry-in; s (DIGIT) sum;
//        co carry-out; c_msb carry into the top bit (for overflow).
module add_slice
    import seq_adder_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign {c[i+1], s[i]} = full_add(x[i], y[i], c[i]);
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder, DIGIT bits per clock, valid/ready on both
// sides. Optional macro SEQ_CHUNK_ADDER_SUB_EN adds a 'sub' input.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, cin
//        (and sub); out_valid/out_ready with sum, cout, ovf.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = ndig_f(WIDTH, DIGIT);
    localparam int CW   = cnt_w_f(NDIG);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [DIGIT-1:0] s;
    logic             co;
    logic             c_msb;
    logic             last;
    logic [WIDTH-1:0] sum_nxt;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    // a - b as a + ~b + 1; cin is ignored in subtract mode.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    add_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .ci   (carry),
        .s    (s),
        .co   (co),
        .c_msb(c_msb)
    );

    assign last = (cnt == CW'(NDIG - 1));

    // New slice enters at the MSB; after NDIG shifts the word is complete.
    assign sum_nxt = (sum >> DIGIT)
                   | (WIDTH'(s) << (WIDTH - DIGIT));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_eff;
                        carry <= c_eff;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    sum   <= sum_nxt;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cout <= co;
                        ovf  <= c_msb ^ co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
